// File: rtl/thermo_pkg.sv
// Shared definitions for the thermostat display path: digit codes, segment
// patterns and the conversion FSM state type.
package thermo_pkg;

  localparam int MAX_TEMP_DEFAULT = 99;

  // Digit codes 0..9 carry their own value; two extra codes for blank and dash.
  typedef logic [3:0] digit_code_t;
  localparam digit_code_t CODE_BLANK = 4'd10;
  localparam digit_code_t CODE_DASH  = 4'd11;

  // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, LATCH} conv_state_t;
  typedef enum logic {SRC_CURRENT, SRC_CHANGED} src_t;

  function automatic logic [6:0] seg_decode(digit_code_t code);
    case (code)
      4'd0:       return SEG_0;
      4'd1:       return SEG_1;
      4'd2:       return SEG_2;
      4'd3:       return SEG_3;
      4'd4:       return SEG_4;
      4'd5:       return SEG_5;
      4'd6:       return SEG_6;
      4'd7:       return SEG_7;
      4'd8:       return SEG_8;
      4'd9:       return SEG_9;
      CODE_DASH:  return SEG_DASH;
      default:    return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/temp_display_driver_if.sv
// Temperature inputs and multiplexed 7-segment outputs of the display driver.
interface temp_display_driver_if;
  logic [7:0] CurrentTemp;
  logic [7:0] ChangedTemp;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output CurrentTemp, ChangedTemp, input an, seg, dp);
  modport slave  (input CurrentTemp, ChangedTemp, output an, seg, dp);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3), one bit per
// cycle; bcd holds its value after done until the next start.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  logic [7:0]  bin_sr;
  logic [11:0] bcd_sr;
  logic [2:0]  bit_cnt;
  logic [11:0] bcd_adj;
  logic [19:0] shifted;

  // NOTE: give every combinationally assigned signal a default before any
  // conditional update, otherwise synthesis infers a latch.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 3; i++) begin
      if (bcd_sr[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_sr} << 1;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        bin_sr  <= bin;
        bcd_sr  <= '0;
        bit_cnt <= '0;
        busy    <= 1'b1;
      end else if (busy) begin
        bcd_sr  <= shifted[19:8];
        bin_sr  <= shifted[7:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign bcd = bcd_sr;

endmodule

// File: rtl/temp_display_driver.sv
// 4-digit multiplexed 7-segment driver: alternately converts the current and
// user-selected temperatures, then scans the four digits at a fixed rate.
module temp_display_driver
  import thermo_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int MAX_TEMP    = MAX_TEMP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  temp_display_driver_if.slave bus
);

  localparam int            CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [9:0]    MAX_VAL = 10'(MAX_TEMP);

  conv_state_t state, state_nxt;
  src_t        src;
  logic        start, busy, done;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [9:0]  bcd_value;
  digit_code_t tens_code, ones_code;
  digit_code_t codes [4];

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;

  assign bin = (src == SRC_CURRENT) ? bus.CurrentTemp : bus.ChangedTemp;

  bin2bcd_seq u_bcd (
    .clk     (clk),
    .Reset_n (Reset_n),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        start     = !busy;
        state_nxt = CONV;
      end
      CONV:    if (done) state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Range check uses the full BCD value; leading zero of a single digit blanks.
  always_comb begin
    bcd_value = 10'(bcd[11:8]) * 10'd100 + 10'(bcd[7:4]) * 10'd10 + 10'(bcd[3:0]);
    tens_code = digit_code_t'(bcd[7:4]);
    ones_code = digit_code_t'(bcd[3:0]);
    if (bcd_value > MAX_VAL) begin
      tens_code = CODE_DASH;
      ones_code = CODE_DASH;
    end else if (bcd[11:4] == 8'd0) begin
      tens_code = CODE_BLANK;
    end
  end

  // NOTE: the four digit codes are plain flops, so resetting them is cheap and
  // guarantees a blank display until the first conversion lands.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      src <= SRC_CURRENT;
      for (int i = 0; i < 4; i++) codes[i] <= CODE_BLANK;
    end else if (state == LATCH) begin
      if (src == SRC_CURRENT) begin
        codes[3] <= tens_code;
        codes[2] <= ones_code;
        src      <= SRC_CHANGED;
      end else begin
        codes[1] <= tens_code;
        codes[0] <= ones_code;
        src      <= SRC_CURRENT;
      end
    end
  end

  // Digit index walks 3->2->1->0 and wraps; an and seg follow it on one edge.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd3;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
    end else begin
      if (refresh_cnt == CNT_MAX) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx - 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + CW'(1);
      end
      an_q  <= ~(4'b0001 << digit_idx);
      seg_q <= seg_decode(codes[digit_idx]);
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_temp_display_driver.sv
// Self-checking bench for temp_display_driver with a 4-cycle digit dwell.
module tb_temp_display_driver;

  localparam int RDIV = 4;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;

  typedef logic [3:0][6:0] frame_t;  // index 3 = leftmost digit
  typedef struct {
    logic [7:0] cur;
    logic [7:0] chg;
    frame_t     exp;
  } vec_t;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   edge_no;
  vec_t vecs [6];

  temp_display_driver_if bus ();

  temp_display_driver #(.REFRESH_DIV(RDIV), .MAX_TEMP(99)) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) edge_no <= 0;
    else          edge_no <= edge_no + 1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic logic [6:0] ref_digit(input int d);
    case (d)
      0: return S0; 1: return S1; 2: return S2; 3: return S3; 4: return S4;
      5: return S5; 6: return S6; 7: return S7; 8: return S8; default: return S9;
    endcase
  endfunction

  function automatic logic [13:0] ref_pair(input int v);
    if (v > 99)     return {SD, SD};
    else if (v < 10) return {SB, ref_digit(v)};
    else             return {ref_digit(v / 10), ref_digit(v % 10)};
  endfunction

  // Wait (from a negedge) until edge n has occurred; bounded by the clock.
  task automatic wait_edge(input int n);
    for (int i = 0; i < 200 && edge_no < n; i++) @(negedge clk);
    check("wait_edge_reached", 8'(edge_no >= n), 8'd1);
  endtask

  task automatic wait_for_an(input logic [3:0] pat, output logic [6:0] s, output bit ok);
    ok = 1'b0;
    s  = '1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.an == pat) begin
        ok = 1'b1;
        s  = bus.seg;
        break;
      end
    end
  endtask

  task automatic check_frame(input string name, input frame_t exp);
    logic [6:0] s;
    logic [3:0] pat;
    bit ok;
    for (int d = 3; d >= 0; d--) begin
      pat = ~(4'b0001 << d);
      wait_for_an(pat, s, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL %s_d%0d: anode %b never selected", name, d, pat);
      end else begin
        check($sformatf("%s_d%0d", name, d), 8'(s), 8'(exp[d]));
      end
    end
  endtask

  // Expects Reset_n low and inputs 70/72; releases reset and checks start-up.
  task automatic initial_sequence(input string tag);
    @(negedge clk);
    Reset_n = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      wait_edge(e);
      check($sformatf("%s_blank_e%0d", tag, e), 8'(bus.seg), 8'(SB));
      if (e == 1) check($sformatf("%s_an_e1", tag), 8'(bus.an), 8'b0111);
      if (e == 5) check($sformatf("%s_an_e5", tag), 8'(bus.an), 8'b1011);
      if (e == 9) check($sformatf("%s_an_e9", tag), 8'(bus.an), 8'b1101);
    end
    wait_edge(13);
    check($sformatf("%s_an_e13", tag), 8'(bus.an), 8'b1110);
    wait_edge(24);
    check_frame($sformatf("%s_7072", tag), {S7, S0, S7, S2});
  endtask

  // Scan monitor: one anode low every cycle, each anode held exactly RDIV cycles.
  initial begin
    logic [3:0] prev_an;
    int run;
    bit tracking;
    tracking = 1'b0;
    prev_an  = '1;
    run      = 0;
    forever begin
      @(negedge clk);
      if (!Reset_n || edge_no < 1) begin
        tracking = 1'b0;
      end else begin
        check("one_anode_low", 8'($countones(~bus.an)), 8'd1);
        if (tracking && bus.an == prev_an) begin
          run++;
        end else begin
          if (tracking) check("dwell", 8'(run), 8'(RDIV));
          run      = 1;
          tracking = 1'b1;
        end
        prev_an = bus.an;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{cur: 8'd70,  chg: 8'd72,  exp: {S7, S0, S7, S2}};
    vecs[1] = '{cur: 8'd0,   chg: 8'd5,   exp: {SB, S0, SB, S5}};
    vecs[2] = '{cur: 8'd150, chg: 8'd99,  exp: {SD, SD, S9, S9}};
    vecs[3] = '{cur: 8'd100, chg: 8'd10,  exp: {SD, SD, S1, S0}};
    vecs[4] = '{cur: 8'd9,   chg: 8'd255, exp: {SB, S9, SD, SD}};
    vecs[5] = '{cur: 8'd38,  chg: 8'd64,  exp: {S3, S8, S6, S4}};

    bus.CurrentTemp = 8'd70;
    bus.ChangedTemp = 8'd72;
    Reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_an", 8'(bus.an), 8'b1111);
    check("reset_seg", 8'(bus.seg), 8'(SB));
    check("reset_dp", 8'(bus.dp), 8'd1);
    initial_sequence("init");

    foreach (vecs[i]) begin
      bus.CurrentTemp = vecs[i].cur;
      bus.ChangedTemp = vecs[i].chg;
      repeat (36) @(negedge clk);
      check_frame($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Changed source sampled at edge 12 (42); input moves to 43 mid-conversion.
    Reset_n = 1'b0;
    bus.CurrentTemp = 8'd20;
    bus.ChangedTemp = 8'd42;
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;
    wait_edge(14);
    bus.ChangedTemp = 8'd43;
    wait_edge(26);
    check("midconv_an_e26", 8'(bus.an), 8'b1101);
    check("midconv_tens_4", 8'(bus.seg), 8'(S4));
    wait_edge(30);
    check("midconv_an_e30", 8'(bus.an), 8'b1110);
    check("midconv_ones_old_2", 8'(bus.seg), 8'(S2));
    wait_edge(46);
    check("midconv_an_e46", 8'(bus.an), 8'b1110);
    check("midconv_ones_new_3", 8'(bus.seg), 8'(S3));

    // Asynchronous reset while the Current source is converting.
    bus.CurrentTemp = 8'd70;
    bus.ChangedTemp = 8'd72;
    wait_edge(50);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_rst_an", 8'(bus.an), 8'b1111);
    check("async_rst_seg", 8'(bus.seg), 8'(SB));
    check("async_rst_dp", 8'(bus.dp), 8'd1);
    initial_sequence("rerst");

    for (int v = 0; v < 256; v++) begin
      bus.CurrentTemp = 8'(v);
      bus.ChangedTemp = 8'(255 - v);
      repeat (36) @(negedge clk);
      check_frame($sformatf("sweep%0d", v), {ref_pair(v), ref_pair(255 - v)});
    end

    check("final_dp", 8'(bus.dp), 8'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
